dot_sequencer: RTL and testbench

Operand sequencer that sits directly upstream of the fixed-point MAC. It holds two small operand buffers (vector A and vector B, 8-bit two's complement, 5 fractional bits), and on `start` clears the MAC, streams `len` operand pairs into it, drains the MAC pipeline, and captures the 8-bit dot-product result. It turns the free-running MAC into a command/response dot-product unit for the control path.

---
 rtl/dot_sequencer.sv | 129 ++++++++++++
 tb/tb_dot_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_sequencer.sv
// dot_sequencer: operand buffers + command FSM feeding a fixed-point MAC.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data   operand buffer write (A when wr_sel=0, B when 1)
//   len, start                pair count and command strobe
//   busy                      operation in progress
//   mac_rst_n/mac_run/mac_a/mac_b  registered drive to the MAC
//   mac_y                     MAC output (sum[12:5])
//   result_valid, result      one-cycle done pulse and captured mac_y
module dot_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW:0]   len,
   input  logic          start,
   output logic          busy,
   output logic          mac_rst_n,
   output logic          mac_run,
   output logic [7:0]    mac_a,
   output logic [7:0]    mac_b,
   input  logic [7:0]    mac_y,
   output logic          result_valid,
   output logic [7:0]    result
);

   localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] ADDR0   = '0;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      SETTLE
   } state_t;

   state_t      state;
   logic [7:0]  buf_a [DEPTH];
   logic [7:0]  buf_b [DEPTH];
   // cnt: clamped pair count; idx: next pair to present (one wider than
   // an address so a full-depth run can reach cnt == DEPTH)
   logic [AW:0] cnt;
   logic [AW:0] idx;

   // Buffers are not reset; writes only land while the FSM idles.
   always_ff @(posedge clk) begin
      if (wr_en && state == IDLE) begin
         if (wr_sel) buf_b[wr_addr] <= wr_data;
         else        buf_a[wr_addr] <= wr_data;
      end
   end

   // All outputs are assigned for the cycle being entered, so they
   // line up exactly with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         mac_rst_n    <= 1'b0;
         mac_run      <= 1'b0;
         mac_a        <= 8'h00;
         mac_b        <= 8'h00;
         result_valid <= 1'b0;
         result       <= 8'h00;
         cnt          <= '0;
         idx          <= '0;
      end else begin
         result_valid <= 1'b0;
         mac_rst_n    <= 1'b1;
         mac_run      <= 1'b0;
         mac_a        <= 8'h00;
         mac_b        <= 8'h00;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  mac_rst_n <= 1'b0;
                  cnt       <= (len > DEPTH_L) ? DEPTH_L : len;
                  idx       <= '0;
               end
            end
            CLEAR: begin
               // Next cycle is either the first pair or, for an empty
               // command, the drain; both run the MAC.
               mac_run <= 1'b1;
               if (cnt == '0) begin
                  state <= DRAIN;
               end else begin
                  state <= STREAM;
                  mac_a <= buf_a[ADDR0];
                  mac_b <= buf_b[ADDR0];
                  idx   <= (AW + 1)'(1);
               end
            end
            STREAM: begin
               mac_run <= 1'b1;
               if (idx == cnt) begin
                  state <= DRAIN;
               end else begin
                  mac_a <= buf_a[idx[AW-1:0]];
                  mac_b <= buf_b[idx[AW-1:0]];
                  idx   <= idx + 1'b1;
               end
            end
            DRAIN: begin
               state <= SETTLE;
            end
            SETTLE: begin
               state        <= IDLE;
               busy         <= 1'b0;
               result_valid <= 1'b1;
               result       <= mac_y;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_sequencer.sv
// tb_dot_sequencer: random + directed bench for dot_sequencer with a
// behavioural MAC and a timeline reference model.
module tb_dot_sequencer;

   logic       clk = 1'b0;
   logic       rst, wr_en, wr_sel, start;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] len;
   logic       busy, mac_rst_n, mac_run, result_valid;
   logic [7:0] mac_a, mac_b, mac_y, result;

   always #5 clk = ~clk;

   dot_sequencer #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .wr_data(wr_data), .len(len), .start(start),
      .busy(busy), .mac_rst_n(mac_rst_n), .mac_run(mac_run),
      .mac_a(mac_a), .mac_b(mac_b), .mac_y(mac_y),
      .result_valid(result_valid), .result(result)
   );

   // MAC: product register feeding an accumulator, Y = sum[12:5]
   logic signed [15:0] prod;
   logic signed [19:0] acc;
   always @(posedge clk) begin
      if (mac_rst_n === 1'b0) begin
         prod <= '0;
         acc  <= '0;
      end else if (mac_run === 1'b1) begin
         prod <= $signed(mac_a) * $signed(mac_b);
         acc  <= acc + 20'(prod);
      end
   end
   assign mac_y = acc[12:5];

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: shadow buffers plus position within the command
   // timeline (cyc = -1 idle, 1 = clear, 2..n+1 stream, n+2 drain, n+3 settle)
   logic [7:0] ma [16];
   logic [7:0] mb [16];
   int   cyc = -1;
   int   n = 0;
   bit   mdl_ok = 0;
   logic e_busy, e_rst_n, e_run, e_rv;
   logic [7:0] e_a, e_b, e_res;

   function automatic logic [7:0] dot(input int cnt);
      int s;
      s = 0;
      for (int i = 0; i < cnt; i++)
         s += int'($signed(ma[i])) * int'($signed(mb[i]));
      return s[12:5];
   endfunction

   always @(posedge clk) begin
      if (cyc == -1 && wr_en) begin
         if (wr_sel) mb[wr_addr] = wr_data;
         else        ma[wr_addr] = wr_data;
      end
      e_rv = 1'b0;
      if (rst) begin
         cyc = -1;
         e_res = 8'h00;
         mdl_ok = 1;
      end else if (cyc == -1) begin
         if (start) begin
            cyc = 1;
            n = (len > 5'd16) ? 16 : int'(len);
         end
      end else if (cyc == n + 3) begin
         cyc = -1;
         e_rv = 1'b1;
         e_res = dot(n);
      end else begin
         cyc++;
      end
      e_busy  = (cyc >= 1);
      e_rst_n = !rst && (cyc != 1);
      e_run   = (cyc >= 2) && (cyc <= n + 2);
      e_a     = (cyc >= 2 && cyc <= n + 1) ? ma[cyc-2] : 8'h00;
      e_b     = (cyc >= 2 && cyc <= n + 1) ? mb[cyc-2] : 8'h00;
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("busy", busy, e_busy);
         chk("mac_rst_n", mac_rst_n, e_rst_n);
         chk("mac_run", mac_run, e_run);
         chk("mac_a", mac_a, e_a);
         chk("mac_b", mac_b, e_b);
         chk("result_valid", result_valid, e_rv);
         chk("result", result, e_res);
      end
   end

   task automatic wr(input logic sel, input logic [3:0] a,
                     input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1;
      wr_sel = sel;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Issues start at a negedge (cycle 0) and counts cycles to result_valid.
   task automatic op(input logic [4:0] l, input bit hold, input bit poke,
                     output int lat, output logic [7:0] res,
                     output int runs);
      len = l;
      start = 1'b1;
      lat = 0;
      runs = 0;
      res = 8'h00;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!hold) start = 1'b0;
            chk("clear_rst_n", mac_rst_n, 0);
         end
         if (mac_run) runs++;
         if (poke && k == 2) begin
            start = 1'b1;
            wr_en = 1'b1;
            wr_sel = 1'b0;
            wr_addr = 4'd0;
            wr_data = 8'h7F;
         end
         if (poke && k == 3) begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         if (result_valid) begin
            lat = k;
            res = result;
            break;
         end
      end
      if (lat == 0) begin
         total++;
         bad++;
         $display("FAIL timeout no result_valid len=%0d", l);
      end
   endtask

   int lat, runs, extra;
   logic [7:0] res;

   initial begin
      rst = 1'b1;
      wr_en = 1'b0;
      wr_sel = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      len = '0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_mac_rst_n", mac_rst_n, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_run", mac_run, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_mac_rst_n", mac_rst_n, 1);

      // 1.0*1.0 + 1.0*2.0 = 3.0
      wr(0, 0, 8'h20); wr(0, 1, 8'h20);
      wr(1, 0, 8'h20); wr(1, 1, 8'h40);
      op(5'd2, 0, 0, lat, res, runs);
      chk("t1_lat", lat, 6);
      chk("t1_res", res, 8'h60);
      chk("t1_runs", runs, 3);

      // -1.0 * 2.0 = -2.0
      wr(0, 0, 8'hE0); wr(1, 0, 8'h40);
      op(5'd1, 0, 0, lat, res, runs);
      chk("t2_lat", lat, 5);
      chk("t2_res", res, 8'hC0);

      op(5'd0, 0, 0, lat, res, runs);
      chk("t3_len0_lat", lat, 4);
      chk("t3_len0_res", res, 8'h00);
      chk("t3_len0_runs", runs, 1);

      // 16 * (1.0 * 0.125) = 2.0; len 31 clamps to 16 pairs
      for (int i = 0; i < 16; i++) begin
         wr(0, 4'(i), 8'h20);
         wr(1, 4'(i), 8'h04);
      end
      op(5'd31, 0, 0, lat, res, runs);
      chk("t3_len31_lat", lat, 20);
      chk("t3_len31_stream", runs - 1, 16);
      chk("t3_len31_res", res, 8'h40);

      // start and write while busy are dropped
      wr(0, 0, 8'hE0); wr(1, 0, 8'h40);
      op(5'd1, 0, 1, lat, res, runs);
      chk("t4_lat", lat, 5);
      chk("t4_res", res, 8'hC0);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      chk("t4_single_rv", extra, 0);
      op(5'd1, 0, 0, lat, res, runs);
      chk("t4_buf_kept", res, 8'hC0);

      // start held through result_valid restarts immediately
      op(5'd1, 1, 0, lat, res, runs);
      chk("t4_hold_lat1", lat, 5);
      op(5'd1, 0, 0, lat, res, runs);
      chk("t4_hold_lat2", lat, 5);
      chk("t4_hold_res", res, 8'hC0);

      // reset during stream
      for (int i = 0; i < 8; i++) wr(0, 4'(i), 8'($urandom));
      len = 5'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_mac_rst_n", mac_rst_n, 0);
      chk("t5_run", mac_run, 0);
      chk("t5_rv", result_valid, 0);
      chk("t5_result", result, 0);
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      chk("t5_no_rv", extra, 0);
      wr(0, 0, 8'h20); wr(1, 0, 8'h20);
      op(5'd1, 0, 0, lat, res, runs);
      chk("t5_res", res, 8'h20);

      // random traffic, checked every cycle by the model
      repeat (3000) begin
         @(negedge clk);
         wr_en = ($urandom % 3) == 0;
         wr_sel = 1'($urandom);
         wr_addr = 4'($urandom);
         wr_data = 8'($urandom);
         start = ($urandom % 4) == 0;
         len = 5'($urandom);
         rst = ($urandom % 300) == 0;
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      repeat (25) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
